// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: FSM states, command/response payloads
// and the watchdog counter width.
package apb_master_pkg;

  localparam int unsigned WDOG_W     = 8;
  localparam int unsigned PKG_ADDR_W = 8;
  localparam int unsigned PKG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb_wdog.sv
// Saturating ACCESS-phase wait counter; flags the wait cycle in which the count
// reaches TIMEOUT. TIMEOUT=0 keeps the flag permanently low.
module apb_wdog
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] MAX   = '1;

  logic [WDOG_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX)) begin
      r_count <= r_count + WDOG_W'(1);
    end
  end

  // Fires in the wait cycle whose increment makes the count equal TIMEOUT.
  assign o_expired_c = (LIMIT != '0) && i_en && (r_count >= (LIMIT - WDOG_W'(1)));

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: one valid/ready command becomes one APB transfer, answered on a
// valid/ready response stream; a watchdog ends accesses whose pready never comes.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = PKG_ADDR_W,
  parameter int unsigned DATA_W  = PKG_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e r_state, w_next;
  cmd_t   r_cmd;
  rsp_t   r_rsp, w_rsp;
  logic   r_cmd_ready, r_psel, r_penable, r_rsp_valid;
  logic   w_accept, w_cap, w_wd_clr, w_wd_en, w_expired;

  apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk        (pclk),
    .rst        (preset),
    .i_clr      (w_wd_clr),
    .i_en       (w_wd_en),
    .o_expired_c(w_expired)
  );

  // Next-state, command accept and response capture decode.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cap    = 1'b0;
    w_wd_clr = 1'b0;
    w_wd_en  = 1'b0;
    w_rsp    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_wd_clr = 1'b1;
          w_next   = ST_SETUP;
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          w_cap         = 1'b1;
          w_rsp.rdata   = r_cmd.write ? '0 : PKG_DATA_W'(prdata);
          w_rsp.err     = pslverr;
          w_next        = ST_RESP;
        end else begin
          w_wd_en = 1'b1;
          if (w_expired) begin
            w_cap         = 1'b1;
            w_rsp.err     = 1'b1;
            w_rsp.timeout = 1'b1;
            w_next        = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, registered handshake/APB controls and payload registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_rsp       <= '0;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable   <= (w_next == ST_ACCESS);
      r_rsp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_cmd.write <= cmd_write;
        r_cmd.addr  <= PKG_ADDR_W'(cmd_addr);
        r_cmd.wdata <= PKG_DATA_W'(cmd_wdata);
      end
      if (w_cap) r_rsp <= w_rsp;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = DATA_W'(r_rsp.rdata);
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_cmd.write;
  assign paddr       = ADDR_W'(r_cmd.addr);
  assign pwdata      = DATA_W'(r_cmd.wdata);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: zero-wait, wait-state, slave-error, timeout,
// timeout/pready tie, back-pressure and mid-transfer reset scenarios.
module tb_apb_cmd_master;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic       rsp_ready = 1'b1;
  logic       rsp_valid, cmd_ready, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b1, pslverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held across edges with a command already pending.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'hA5;
    tick(); tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk1("rst_pwrite", pwrite, 1'b0);
    chk8("rst_paddr", paddr, 8'h00);
    chk8("rst_pwdata", pwdata, 8'h00);
    chk8("rst_rdata", rsp_rdata, 8'h00);
    chk1("rst_err", rsp_err, 1'b0);
    chk1("rst_timeout", rsp_timeout, 1'b0);
    preset = 1'b0;

    // Zero-wait write accepted on the first edge after reset release.
    tick();
    chk1("wr_setup_psel", psel, 1'b1);
    chk1("wr_setup_penable", penable, 1'b0);
    chk1("wr_setup_cmd_ready", cmd_ready, 1'b0);
    chk1("wr_pwrite", pwrite, 1'b1);
    chk8("wr_pwdata", pwdata, 8'hA5);
    cmd_valid = 1'b0;
    tick();
    chk1("wr_access_psel", psel, 1'b1);
    chk1("wr_access_penable", penable, 1'b1);
    chk1("wr_access_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk1("wr_resp_valid", rsp_valid, 1'b1);
    chk1("wr_resp_psel", psel, 1'b0);
    chk8("wr_resp_rdata", rsp_rdata, 8'h00);
    chk1("wr_resp_err", rsp_err, 1'b0);
    tick();
    chk1("wr_idle_valid", rsp_valid, 1'b0);
    chk1("wr_idle_cmd_ready", cmd_ready, 1'b1);

    // Read with three wait states; prdata is junk until pready.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02; pready = 1'b0; prdata = 8'h11;
    tick();
    cmd_valid = 1'b0; cmd_addr = 8'hFF;
    chk8("rd_setup_paddr", paddr, 8'h02);
    chk1("rd_setup_pwrite", pwrite, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rd_access_penable", penable, 1'b1);
      chk8("rd_access_paddr", paddr, 8'h02);
      chk1("rd_access_rsp_valid", rsp_valid, 1'b0);
      if (i == 3) begin
        pready = 1'b1; prdata = 8'h7F;
      end
    end
    tick();
    chk1("rd_resp_valid", rsp_valid, 1'b1);
    chk8("rd_resp_rdata", rsp_rdata, 8'h7F);
    chk1("rd_resp_err", rsp_err, 1'b0);
    tick();

    // Slave error on a read still returns prdata, then a clean write follows.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; prdata = 8'h55; pslverr = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick();
    tick();
    pslverr = 1'b0;
    chk1("err_resp_valid", rsp_valid, 1'b1);
    chk1("err_resp_err", rsp_err, 1'b1);
    chk1("err_resp_timeout", rsp_timeout, 1'b0);
    chk8("err_resp_rdata", rsp_rdata, 8'h55);
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 8'h3C;
    tick(); cmd_valid = 1'b0;
    chk8("after_err_paddr", paddr, 8'h04);
    tick();
    tick();
    chk1("after_err_valid", rsp_valid, 1'b1);
    chk1("after_err_err", rsp_err, 1'b0);
    chk8("after_err_rdata", rsp_rdata, 8'h00);
    tick();

    // Stuck slave: exactly 16 ACCESS cycles, then timeout response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05; pready = 1'b0; prdata = 8'hEE;
    pslverr = 1'b1;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1("to_access_penable", penable, 1'b1);
      chk1("to_access_rsp_valid", rsp_valid, 1'b0);
    end
    tick();
    chk1("to_psel", psel, 1'b0);
    chk1("to_penable", penable, 1'b0);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_err", rsp_err, 1'b1);
    chk1("to_timeout", rsp_timeout, 1'b1);
    chk8("to_rdata", rsp_rdata, 8'h00);
    pslverr = 1'b0;
    tick();

    // pready arriving in the 16th ACCESS cycle wins over the watchdog.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h06; prdata = 8'h44;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1("tie_access_penable", penable, 1'b1);
      if (i == 15) begin
        pready = 1'b1; prdata = 8'h99;
      end
    end
    tick();
    chk1("tie_rsp_valid", rsp_valid, 1'b1);
    chk1("tie_err", rsp_err, 1'b0);
    chk1("tie_timeout", rsp_timeout, 1'b0);
    chk8("tie_rdata", rsp_rdata, 8'h99);
    tick();

    // Response back-pressure with a second command waiting.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h07; cmd_wdata = 8'h12;
    tick();
    cmd_addr = 8'h08; cmd_wdata = 8'h34;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk8("bp_paddr", paddr, 8'h07);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk1("bp_release_cmd_ready", cmd_ready, 1'b1);
    chk1("bp_release_valid", rsp_valid, 1'b0);
    tick();
    chk8("bp_second_paddr", paddr, 8'h08);
    chk1("bp_second_psel", psel, 1'b1);
    cmd_valid = 1'b0; pready = 1'b0;
    tick();
    tick();
    chk1("mid_access_penable", penable, 1'b1);

    // Asynchronous reset in the middle of ACCESS.
    #2 preset = 1'b1;
    #1;
    chk1("arst_psel", psel, 1'b0);
    chk1("arst_penable", penable, 1'b0);
    chk1("arst_rsp_valid", rsp_valid, 1'b0);
    chk1("arst_cmd_ready", cmd_ready, 1'b1);
    chk8("arst_paddr", paddr, 8'h00);
    preset = 1'b0; pready = 1'b1;
    tick();
    tick();
    chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("post_rst_psel", psel, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB3 requester that turns a simple valid/ready command stream into single APB transfers on `pclk`, and returns each transfer's read data and error status on a valid/ready response stream. It sits directly upstream of the 8-bit timer peripheral, whose APB slave port it drives: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `prdata`, `pready` and `pslverr`. A watchdog ends any access whose `pready` never arrives, so a hung slave cannot stall the command source.

## Interface
Parameters:
- `ADDR_W`, 8, width of the APB address and of `cmd_addr`.
- `DATA_W`, 8, width of the APB data buses and of the command/response data.
- `TIMEOUT`, 16, number of ACCESS cycles with `pready` low that ends the transfer; 0 disables the watchdog; range 0..255.

Ports:
- `pclk` in 1: sole clock; all logic is rising-edge.
- `preset` in 1: asynchronous, active-high reset (single clock domain).
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the command is accepted on a cycle with `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target register address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the response is consumed on a cycle with `rsp_valid && rsp_ready`.
- `rsp_rdata` out DATA_W: read data; 0 for writes and for timed-out transfers.
- `rsp_err` out 1: the slave returned `pslverr`, or the transfer timed out.
- `rsp_timeout` out 1: the transfer timed out.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB transfer complete.
- `pslverr` in 1: APB slave error.

## Operation
FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE:** `cmd_ready`=1. On accept, latch write/addr/wdata into the command register and go to SETUP.
- **SETUP:** `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- **ACCESS:** `psel`=1, `penable`=1.
  - On `pready`=1: capture `rsp_rdata` = read ? `prdata` : 0, `rsp_err` = `pslverr`, `rsp_timeout` = 0; go to RESP.
  - On `pready`=0: increment the watchdog count. When the count reaches TIMEOUT (TIMEOUT≠0): capture `rsp_rdata`=0, `rsp_err`=1, `rsp_timeout`=1; go to RESP.
- **RESP:** `rsp_valid`=1 and the response fields are held stable. On `rsp_ready`, go to IDLE.
- `cmd_ready`=0 in every state except IDLE. There is one outstanding transfer at a time and no queue.
- `paddr`, `pwrite` and `pwdata` are driven from the command register. They are stable from SETUP through the last ACCESS cycle and keep their last value outside a transfer.
- The watchdog count clears on entry to SETUP. It is 8 bits wide and saturating.
- `pslverr` and `prdata` are sampled only in the ACCESS cycle where `pready`=1; they are ignored in every other cycle.

## Timing
- Reset values:
  - FSM = IDLE.
  - `cmd_ready`=1.
  - `rsp_valid`=0, `psel`=0, `penable`=0, `pwrite`=0.
  - `paddr`=0, `pwdata`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0.
  - Watchdog count = 0.
- Zero-wait transfer: accept at edge T; SETUP in cycle T+1; ACCESS in T+2 (`pready`=1); `rsp_valid` in T+3.
  - With `rsp_ready` already high, the block is back in IDLE at T+4 and accepts the next command then.
  - Minimum issue interval is 4 cycles.
- Each wait cycle (`pready`=0) adds one cycle to the ACCESS phase.
- Timeout: with `pready` held at 0, exactly TIMEOUT ACCESS cycles are asserted. `psel` and `penable` fall on the next edge, together with `rsp_valid` rising.
- A `pready` that arrives in the same cycle the count reaches TIMEOUT takes priority: the transfer completes normally.
- `rsp_ready` held low keeps the block in RESP indefinitely; commands are back-pressured.
- `preset` asserted in any state returns all outputs to their reset values immediately.
  - The in-flight command is dropped and no response is issued.
  - `psel` falls asynchronously.
- `cmd_valid` in a non-IDLE state is ignored; the command source must hold it until `cmd_ready`.

## Structure
- Package `apb_master_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SETUP`, `ST_ACCESS`, `ST_RESP`).
  - Packed command struct {write, addr, wdata}.
  - Packed response struct {rdata, err, timeout}.
  - Localparam for the watchdog count width (8).
- Sub-module `apb_wdog`: saturating 8-bit counter with clear/enable and a `TIMEOUT` compare output (`expired`), held inactive when TIMEOUT=0.
- The FSM and the command/response registers live in the top module.

## Test plan
- Reset with `cmd_valid`=1 → all outputs at reset values and `cmd_ready`=1; the first command is accepted on the first edge after `preset` deasserts.
- Write addr 0x00 data 0xA5, `pready` tied 1, `rsp_ready`=1 → `psel` high for 2 cycles; `penable` high in the second cycle only; `rsp_valid` 3 cycles after accept; `rsp_rdata`=0x00, `rsp_err`=0.
- Read addr 0x02, slave inserts 3 wait states and returns 0x7F → ACCESS lasts 4 cycles; `paddr` stays 0x02 throughout; `rsp_rdata`=0x7F.
- Read addr 0x03, slave returns `pslverr`=1 with `pready` → `rsp_err`=1, `rsp_timeout`=0; the next command still completes normally.
- TIMEOUT=16, `pready` stuck 0 → 16 ACCESS cycles, then `psel`=0 and `rsp_valid`=1 with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- `rsp_ready` held 0 for 10 cycles with `cmd_valid`=1, then `preset` pulsed mid-ACCESS on a later transfer → no second accept while in RESP; after reset there is no stale `rsp_valid` and `psel`=0.
